wb_uart_lane_bridge: RTL and testbench
======================================

# wb_uart_lane_bridge

Parametrised Wishbone B3 classic slave that lets a wide system bus reach the 8-bit UART register file. Each bus access whose byte selects cover several lanes becomes a sequence of single-byte register accesses, lowest lane first. Read bytes are reassembled onto the full bus word, and a single ack, or an error on downstream timeout, is returned. The block sits between the system Wishbone interconnect and the UART core's register port.

## Interface
- DATA_W, 32, bus data width; legal values are 8, 16 and 32. NB = DATA_W/8.
- ADDR_W, 3, width of the word address.
- TIMEOUT, 15, maximum number of cycles to wait for reg_ack_i per byte; legal range 1..255.
- clk  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_adr_i  in  ADDR_W  word address
- wb_sel_i  in  NB  byte-lane selects
- wb_dat_i  in  DATA_W  write data
- wb_dat_o  out  DATA_W  read data
- wb_we_i, wb_stb_i, wb_cyc_i  in  1 each  Wishbone write, strobe and cycle
- wb_ack_o  out  1  transfer done
- wb_err_o  out  1  transfer aborted by timeout
- reg_req_o  out  1  downstream byte request
- reg_we_o  out  1  downstream write
- reg_addr_o  out  3  UART register index
- reg_wdata_o  out  8  downstream write byte
- reg_rdata_i  in  8  downstream read byte; valid while reg_ack_i is high
- reg_ack_i  in  1  downstream completion; ignored while reg_req_o is low

## Operation
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE: when wb_cyc_i and wb_stb_i are both high, latch address, sel, we and data, and clear the read accumulator.
  - sel of zero: go to RESP with no downstream access.
  - Otherwise: go to ACCESS on the lowest set lane.
- ACCESS
  - reg_req_o is high.
  - reg_addr_o = (wb_adr_i*NB + lane)[2:0].
  - reg_wdata_o = latched byte for that lane.
  - reg_we_o = latched we.
- On reg_ack_i in ACCESS:
  - Read: store reg_rdata_i into lane bits [8*lane +: 8].
  - Clear that lane's pending bit.
  - If other lanes are still pending, move to the next lowest one. reg_req_o stays high; address and data update the following cycle.
  - Otherwise go to RESP.
- RESP: wb_ack_o is high for 1 cycle. wb_dat_o carries the accumulator; unselected lanes read 0. Then IDLE.
- ERR: wb_err_o is high for 1 cycle and wb_dat_o = 0. Then IDLE. Lanes still pending are not issued.
- wb_cyc_i dropping mid-ACCESS: the current byte is always completed, because a UART read has side effects (FIFO pop). Remaining lanes are dropped and the block returns to IDLE with no ack and no err.
- Reset, including mid-operation: state goes to IDLE immediately, and every output and internal register goes to 0.
- wb_dat_o is 0 in every cycle except the RESP cycle.

## Timing
- A new request is sampled only in IDLE. After RESP or ERR there is one mandatory IDLE cycle before the next request is accepted.
- Per-lane cost: 1 + w cycles, where w is the number of cycles reg_ack_i arrives after the request.
- Total latency: the request is seen at cycle 0; wb_ack_o is high at cycle 1 + Σ(1+w_i).
- Zero-wait single byte: ack at cycle 2.
- Zero-wait sel=4'b1111: ack at cycle 5.
- Empty sel: ack at cycle 1.
- Timeout: the counter resets on every lane start. reg_ack_i absent for TIMEOUT consecutive ACCESS cycles moves the FSM to ERR on the next cycle and drops reg_req_o.
- reg_ack_i arriving in the same cycle the counter reaches TIMEOUT: the ack wins.

## Configuration
- BRIDGE_TIMEOUT_EN defined: timeout counter, ERR state and wb_err_o are active as described above.
- BRIDGE_TIMEOUT_EN undefined: ACCESS waits for reg_ack_i indefinitely, wb_err_o is tied to 0, and the counter logic is not built.

## Structure
- uart_bridge_pkg holds:
  - bridge_state_e enum;
  - REG_ADDR_W = 3;
  - lowest_set(sel) priority function;
  - legal-DATA_W check constant.
- Sub-module bridge_timeout: a counter with clear, enable and expired outputs, instantiated only under BRIDGE_TIMEOUT_EN.

## Test plan
- DATA_W=32, write, adr=1, sel=4'b0101, dat=32'hA1B2C3D4, zero wait. Required: downstream writes are (addr 4, D4) then (addr 6, B2); wb_ack_o is high at cycle 3.
- Read, adr=0, sel=4'b1111, downstream returns 11/22/33/44, w=2 on each lane. Required: wb_dat_o = 32'h44332211 during ack at cycle 13.
- sel=0. Required: ack at cycle 1, reg_req_o never asserted, wb_dat_o = 0.
- BRIDGE_TIMEOUT_EN, TIMEOUT=15, reg_ack_i held low. Required: wb_err_o is high for exactly 1 cycle, 16 cycles after the lane starts, and no ack is issued.
- wb_cyc_i dropped during lane 0 of sel=4'b0011 with w=3. Required: lane 0 completes, lane 1 is never requested, and neither ack nor err is asserted.
- wb_rst_i pulsed mid-ACCESS. Required: reg_req_o, wb_ack_o and wb_dat_o are 0 immediately, and the next request completes normally.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared types and helpers for the wide-bus to 8-bit UART register bridge.
// The optional downstream timeout is enabled by defining BRIDGE_TIMEOUT_EN.
package uart_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2,
      ERR    = 2'd3
   } bridge_state_e;

   localparam int REG_ADDR_W = 3;
   localparam int MAX_LANES  = 4;

   // Index of the lowest set lane; 0 when nothing is set.
   function automatic logic [1:0] lowest_set(input logic [MAX_LANES-1:0] sel);
      logic [1:0] idx;
      idx = '0;
      for (int i = MAX_LANES - 1; i >= 0; i--) begin
         if (sel[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   function automatic bit data_w_legal(input int w);
      return (w == 8) || (w == 16) || (w == 32);
   endfunction

endpackage

// File: rtl/bridge_timeout.sv
// Per-lane downstream timeout: reloads on clear, counts down while enabled,
// and flags expiry at terminal count. Only instantiated with BRIDGE_TIMEOUT_EN.
module bridge_timeout #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= 8'(LIMIT);
      end else if (enable && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 8'd1;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/wb_uart_lane_bridge.sv
// Wishbone classic slave splitting multi-lane accesses into byte accesses on
// the UART register port. Downstream timeout/err only with BRIDGE_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for cyc & stb; request latched here
// ACCESS | byte request outstanding on the current lane
// RESP   | one-cycle ack with reassembled read data
// ERR    | one-cycle err after a downstream timeout
module wb_uart_lane_bridge
   import uart_bridge_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 3,
   parameter int TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  wb_rst_i,
   input  logic [ADDR_W-1:0]     wb_adr_i,
   input  logic [DATA_W/8-1:0]   wb_sel_i,
   input  logic [DATA_W-1:0]     wb_dat_i,
   output logic [DATA_W-1:0]     wb_dat_o,
   input  logic                  wb_we_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_cyc_i,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
   output logic                  reg_req_o,
   output logic                  reg_we_o,
   output logic [REG_ADDR_W-1:0] reg_addr_o,
   output logic [7:0]            reg_wdata_o,
   input  logic [7:0]            reg_rdata_i,
   input  logic                  reg_ack_i
);

   localparam int NB  = DATA_W / 8;
   localparam int LSH = (NB == 4) ? 2 : ((NB == 2) ? 1 : 0);

   if (!data_w_legal(DATA_W) || (TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_param
      $error("wb_uart_lane_bridge: illegal DATA_W or TIMEOUT");
   end

   bridge_state_e     state_q, state_d;
   logic [ADDR_W-1:0] adr_q;
   logic [NB-1:0]     pend_q, pend_left, lane_mask;
   logic [DATA_W-1:0] dat_q, acc_q;
   logic [1:0]        lane_q;
   logic [ADDR_W+1:0] addr_ext;
   logic              we_q, abort_q, accept, drop, in_access, expired;

   assign in_access = (state_q == ACCESS);
   assign accept    = (state_q == IDLE) && wb_cyc_i && wb_stb_i;
   // A byte already on the UART port must finish (reads pop FIFOs), so a
   // dropped cycle only takes effect once the current lane is acknowledged.
   assign drop      = abort_q || !wb_cyc_i;
   assign lane_mask = NB'(1) << lane_q;
   assign pend_left = pend_q & ~lane_mask;

`ifdef BRIDGE_TIMEOUT_EN
   bridge_timeout #(.LIMIT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (wb_rst_i),
      .clear   (!in_access || reg_ack_i),
      .enable  (in_access),
      .expired (expired)
   );
   assign wb_err_o = (state_q == ERR);
`else
   assign expired  = 1'b0;
   assign wb_err_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = (wb_sel_i == '0) ? RESP : ACCESS;
         end
         ACCESS: begin
            if (reg_ack_i) begin
               if (drop)                   state_d = IDLE;
               else if (pend_left != '0)   state_d = ACCESS;
               else                        state_d = RESP;
            end else if (expired) begin
               state_d = drop ? IDLE : ERR;
            end
         end
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         adr_q   <= '0;
         pend_q  <= '0;
         we_q    <= 1'b0;
         dat_q   <= '0;
         acc_q   <= '0;
         lane_q  <= '0;
         abort_q <= 1'b0;
      end else begin
         if (accept) begin
            adr_q   <= wb_adr_i;
            pend_q  <= wb_sel_i;
            we_q    <= wb_we_i;
            dat_q   <= wb_dat_i;
            acc_q   <= '0;
            lane_q  <= lowest_set(MAX_LANES'(wb_sel_i));
            abort_q <= 1'b0;
         end
         if (in_access && !wb_cyc_i) abort_q <= 1'b1;
         if (in_access && reg_ack_i) begin
            if (!we_q) acc_q[8*lane_q +: 8] <= reg_rdata_i;
            pend_q <= pend_left;
            lane_q <= lowest_set(MAX_LANES'(pend_left));
         end
      end
   end

   assign addr_ext    = (ADDR_W+2)'(adr_q) << LSH;
   assign reg_req_o   = in_access;
   assign reg_we_o    = in_access && we_q;
   assign reg_addr_o  = in_access ? REG_ADDR_W'(addr_ext + (ADDR_W+2)'(lane_q)) : '0;
   assign reg_wdata_o = in_access ? dat_q[8*lane_q +: 8] : '0;
   assign wb_ack_o    = (state_q == RESP);
   assign wb_dat_o    = (state_q == RESP) ? acc_q : '0;

endmodule

// File: tb/tb_wb_uart_lane_bridge.sv
// Self-checking bench for wb_uart_lane_bridge (DATA_W=32); timeout cases run
// only when BRIDGE_TIMEOUT_EN is defined.
module tb_wb_uart_lane_bridge;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 3;

   typedef struct {
      logic        we;
      logic [2:0]  adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      int          w;
      logic [31:0] exp_dat;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [2:0] addr;
      logic       we;
      logic [7:0] wdata;
   } acc_t;

   logic        clk = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic [2:0]  wb_adr_i = '0;
   logic [3:0]  wb_sel_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
   logic        wb_ack_o, wb_err_o;
   logic        reg_req_o, reg_we_o;
   logic [2:0]  reg_addr_o;
   logic [7:0]  reg_wdata_o;
   logic [7:0]  reg_rdata_i = '0;
   logic        reg_ack_i = 1'b0;

   wb_uart_lane_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
      .clk         (clk),
      .wb_rst_i    (wb_rst_i),
      .wb_adr_i    (wb_adr_i),
      .wb_sel_i    (wb_sel_i),
      .wb_dat_i    (wb_dat_i),
      .wb_dat_o    (wb_dat_o),
      .wb_we_i     (wb_we_i),
      .wb_stb_i    (wb_stb_i),
      .wb_cyc_i    (wb_cyc_i),
      .wb_ack_o    (wb_ack_o),
      .wb_err_o    (wb_err_o),
      .reg_req_o   (reg_req_o),
      .reg_we_o    (reg_we_o),
      .reg_addr_o  (reg_addr_o),
      .reg_wdata_o (reg_wdata_o),
      .reg_rdata_i (reg_rdata_i),
      .reg_ack_i   (reg_ack_i)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail = 0;
   acc_t exp_q[$];
   int   resp_wait = 0;
   bit   resp_hold = 1'b0;
   int   wcnt = 0;
   int   req_cycles = 0;
   logic [3:0] nib;
   acc_t e;
   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Downstream UART model: acks resp_wait cycles after each request; read
   // data for register a is {a+1, a+1}. Each access is matched to the queue.
   always @(negedge clk) begin
      if (reg_ack_i) begin
         reg_ack_i = 1'b0;
         wcnt = 0;
      end
      if (wb_rst_i || !reg_req_o) begin
         wcnt = 0;
      end else begin
         req_cycles++;
         if (!resp_hold) begin
            if (wcnt == resp_wait) begin
               nib = 4'(reg_addr_o) + 4'd1;
               reg_rdata_i = {nib, nib};
               reg_ack_i = 1'b1;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_access: addr %0d we %0b, no access required", reg_addr_o, reg_we_o);
               end else begin
                  e = exp_q.pop_front();
                  check("access_addr", 64'(reg_addr_o), 64'(e.addr));
                  check("access_we", 64'(reg_we_o), 64'(e.we));
                  if (e.we) check("access_wdata", 64'(reg_wdata_o), 64'(e.wdata));
               end
            end else begin
               wcnt++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!wb_rst_i && !wb_ack_o) check("dat_zero_outside_resp", 64'(wb_dat_o), 64'd0);
   end

   task automatic drive_req(input vec_t v, input bit push_all);
      acc_t a;
      int   ai;
      @(negedge clk);
      wb_we_i = v.we; wb_adr_i = v.adr; wb_sel_i = v.sel; wb_dat_i = v.dat;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      resp_wait = v.w;
      req_cycles = 0;
      for (int l = 0; l < 4; l++) begin
         if (v.sel[l] && (push_all || l == 0)) begin
            ai = int'(v.adr) * 4 + l;
            a.addr = 3'(ai);
            a.we = v.we;
            a.wdata = v.dat[8*l +: 8];
            exp_q.push_back(a);
         end
      end
      @(posedge clk);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int k;
      bit done;
      drive_req(v, 1'b1);
      done = 1'b0;
      k = 0;
      while (!done && k < 200) begin
         @(negedge clk);
         k++;
         if (wb_ack_o || wb_err_o) done = 1'b1;
      end
      check({name, "_done"}, 64'(done), 64'd1);
      check({name, "_latency"}, 64'(k), 64'(v.exp_lat));
      check({name, "_rdata"}, 64'(wb_dat_o), 64'(v.exp_dat));
      check({name, "_err"}, 64'(wb_err_o), 64'd0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      check({name, "_accesses_left"}, 64'(exp_q.size()), 64'd0);
      if (v.sel == 4'b0000) check({name, "_no_req"}, 64'(req_cycles), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ack_cnt, err_cnt, first_err;
      vec_t v;

      //          we    adr   sel      dat           w  exp_dat        lat
      vecs.push_back('{1'b1, 3'd1, 4'b0101, 32'hA1B2C3D4, 0, 32'h00000000, 3});
      vecs.push_back('{1'b0, 3'd0, 4'b1111, 32'h00000000, 2, 32'h44332211, 13});
      vecs.push_back('{1'b0, 3'd3, 4'b0000, 32'h00000000, 0, 32'h00000000, 1});
      vecs.push_back('{1'b0, 3'd1, 4'b1000, 32'h00000000, 0, 32'h88000000, 2});
      vecs.push_back('{1'b1, 3'd0, 4'b1111, 32'h01020304, 0, 32'h00000000, 5});
      vecs.push_back('{1'b0, 3'd1, 4'b0110, 32'h00000000, 1, 32'h00776600, 5});
      vecs.push_back('{1'b0, 3'd2, 4'b1111, 32'h00000000, 0, 32'h44332211, 5});
      vecs.push_back('{1'b1, 3'd7, 4'b1001, 32'hDEADBEEF, 3, 32'h00000000, 9});

      @(negedge clk);
      @(negedge clk);
      check("reset_outputs",
            64'({wb_ack_o, wb_err_o, reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o, wb_dat_o}), 64'd0);
      wb_rst_i = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // cyc dropped during lane 0: only lane 0 is issued, no ack or err
      v = '{1'b0, 3'd0, 4'b0011, 32'h0, 3, 32'h0, 0};
      drive_req(v, 1'b0);
      @(negedge clk);
      @(negedge clk);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      ack_cnt = 0; err_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (wb_ack_o) ack_cnt++;
         if (wb_err_o) err_cnt++;
      end
      check("drop_ack", 64'(ack_cnt), 64'd0);
      check("drop_err", 64'(err_cnt), 64'd0);
      check("drop_lane0_done", 64'(exp_q.size()), 64'd0);
      check("drop_req_idle", 64'(reg_req_o), 64'd0);
      exp_q.delete();

      // reset pulse mid-ACCESS, then a normal transfer
      v = '{1'b0, 3'd0, 4'b1111, 32'h0, 5, 32'h0, 0};
      drive_req(v, 1'b0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      check("rst_pre_req", 64'(reg_req_o), 64'd1);
      wb_rst_i = 1'b1;
      #1;
      check("rst_req", 64'(reg_req_o), 64'd0);
      check("rst_ack", 64'(wb_ack_o), 64'd0);
      check("rst_dat", 64'(wb_dat_o), 64'd0);
      check("rst_port", 64'({reg_we_o, reg_addr_o, reg_wdata_o}), 64'd0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(negedge clk);
      wb_rst_i = 1'b0;
      run_vec(vecs[1], "post_reset");

`ifdef BRIDGE_TIMEOUT_EN
      // ack arriving on the terminal count still wins
      run_vec('{1'b0, 3'd0, 4'b0001, 32'h0, 15, 32'h00000011, 17}, "ack_at_limit");

      // no ack at all: err for exactly one cycle, 16 cycles after lane start
      resp_hold = 1'b1;
      v = '{1'b0, 3'd0, 4'b0001, 32'h0, 0, 32'h0, 0};
      drive_req(v, 1'b0);
      exp_q.delete();
      ack_cnt = 0; err_cnt = 0; first_err = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (wb_ack_o) ack_cnt++;
         if (wb_err_o) begin
            err_cnt++;
            if (first_err == 0) first_err = k;
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
         end
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      check("timeout_err_cycle", 64'(first_err), 64'd17);
      check("timeout_err_width", 64'(err_cnt), 64'd1);
      check("timeout_no_ack", 64'(ack_cnt), 64'd0);
      check("timeout_req_dropped", 64'(reg_req_o), 64'd0);
      resp_hold = 1'b0;
`endif

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
